// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a single-ported register file.
// Each transaction takes three cycles: IDLE (sample) -> ACCESS (rf strobe) -> RESP (response).
module regfile_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int RO_LAST  = 1,
  parameter int ADDR_MAX = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_r_wn,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_r_wn,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic              rf_en,
  output logic              rf_r_wn,
  output logic [ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [DATA_W-1:0] rf_rdata
);

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(ADDR_MAX);
  localparam logic [ADDR_W-1:0] RO_A  = ADDR_W'(RO_LAST);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t state_reg, state_next;

  // ptr: 1 = B was granted last. owner: 1 = B owns the transaction in flight.
  logic ptr_reg, ptr_next;
  logic owner_reg, owner_next;
  logic r_wn_reg, r_wn_next;
  logic legal_reg, legal_next;

  logic              a_gnt_reg, a_gnt_next;
  logic              b_gnt_reg, b_gnt_next;
  logic              rf_en_reg, rf_en_next;
  logic              rf_r_wn_reg, rf_r_wn_next;
  logic [ADDR_W-1:0] rf_addr_reg, rf_addr_next;
  logic [DATA_W-1:0] rf_wdata_reg, rf_wdata_next;
  logic              a_rvalid_reg, a_rvalid_next;
  logic              b_rvalid_reg, b_rvalid_next;
  logic              a_err_reg, a_err_next;
  logic              b_err_reg, b_err_next;
  logic              a_rsel_reg, a_rsel_next;
  logic              b_rsel_reg, b_rsel_next;

  logic              win_b;
  logic              sel_r_wn;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_legal;

  always_comb begin
    // B wins when it is alone, or when both request and A was granted last.
    win_b     = b_req && (!a_req || !ptr_reg);
    sel_r_wn  = win_b ? b_r_wn  : a_r_wn;
    sel_addr  = win_b ? b_addr  : a_addr;
    sel_wdata = win_b ? b_wdata : a_wdata;
    sel_legal = (sel_addr <= MAX_A) && (sel_r_wn || (sel_addr > RO_A));
  end

  always_comb begin
    state_next    = state_reg;
    ptr_next      = ptr_reg;
    owner_next    = owner_reg;
    r_wn_next     = r_wn_reg;
    legal_next    = legal_reg;
    a_gnt_next    = 1'b0;
    b_gnt_next    = 1'b0;
    rf_en_next    = 1'b0;
    rf_r_wn_next  = 1'b1;
    rf_addr_next  = '0;
    rf_wdata_next = '0;
    a_rvalid_next = 1'b0;
    b_rvalid_next = 1'b0;
    a_err_next    = 1'b0;
    b_err_next    = 1'b0;
    a_rsel_next   = 1'b0;
    b_rsel_next   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (a_req || b_req) begin
          state_next    = ACCESS;
          ptr_next      = win_b;
          owner_next    = win_b;
          r_wn_next     = sel_r_wn;
          legal_next    = sel_legal;
          a_gnt_next    = !win_b;
          b_gnt_next    = win_b;
          rf_en_next    = sel_legal;
          rf_r_wn_next  = sel_r_wn;
          rf_addr_next  = sel_addr;
          rf_wdata_next = sel_wdata;
        end
      end
      ACCESS: begin
        state_next    = RESP;
        a_rvalid_next = !owner_reg;
        b_rvalid_next = owner_reg;
        a_err_next    = !owner_reg && !legal_reg;
        b_err_next    = owner_reg && !legal_reg;
        a_rsel_next   = !owner_reg && legal_reg && r_wn_reg;
        b_rsel_next   = owner_reg && legal_reg && r_wn_reg;
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      ptr_reg      <= 1'b1;
      owner_reg    <= 1'b0;
      r_wn_reg     <= 1'b0;
      legal_reg    <= 1'b0;
      a_gnt_reg    <= 1'b0;
      b_gnt_reg    <= 1'b0;
      rf_en_reg    <= 1'b0;
      rf_r_wn_reg  <= 1'b1;
      rf_addr_reg  <= '0;
      rf_wdata_reg <= '0;
      a_rvalid_reg <= 1'b0;
      b_rvalid_reg <= 1'b0;
      a_err_reg    <= 1'b0;
      b_err_reg    <= 1'b0;
      a_rsel_reg   <= 1'b0;
      b_rsel_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      owner_reg    <= owner_next;
      r_wn_reg     <= r_wn_next;
      legal_reg    <= legal_next;
      a_gnt_reg    <= a_gnt_next;
      b_gnt_reg    <= b_gnt_next;
      rf_en_reg    <= rf_en_next;
      rf_r_wn_reg  <= rf_r_wn_next;
      rf_addr_reg  <= rf_addr_next;
      rf_wdata_reg <= rf_wdata_next;
      a_rvalid_reg <= a_rvalid_next;
      b_rvalid_reg <= b_rvalid_next;
      a_err_reg    <= a_err_next;
      b_err_reg    <= b_err_next;
      a_rsel_reg   <= a_rsel_next;
      b_rsel_reg   <= b_rsel_next;
    end
  end

  assign a_gnt    = a_gnt_reg;
  assign b_gnt    = b_gnt_reg;
  assign rf_en    = rf_en_reg;
  assign rf_r_wn  = rf_r_wn_reg;
  assign rf_addr  = rf_addr_reg;
  assign rf_wdata = rf_wdata_reg;
  assign a_rvalid = a_rvalid_reg;
  assign b_rvalid = b_rvalid_reg;
  assign a_err    = a_err_reg;
  assign b_err    = b_err_reg;

  // rf_rdata is already registered by the register file; a select flop gates it onto
  // the winner's channel so read data lands in the RESP cycle.
  assign a_rdata = {DATA_W{a_rsel_reg}} & rf_rdata;
  assign b_rdata = {DATA_W{b_rsel_reg}} & rf_rdata;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a small behavioural register file model.
module tb_regfile_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_r_wn, b_req, b_r_wn;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, a_err, b_gnt, b_rvalid, b_err;
  logic [31:0] a_rdata, b_rdata;
  logic        rf_en, rf_r_wn;
  logic [4:0]  rf_addr;
  logic [31:0] rf_wdata, rf_rdata;

  int tests_run = 0;
  int tests_failed = 0;

  regfile_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_r_wn(a_r_wn), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_r_wn(b_r_wn), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata), .b_err(b_err),
    .rf_en(rf_en), .rf_r_wn(rf_r_wn), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .rf_rdata(rf_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rd_val(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h4844_5256;
    return {16'hC0DE, 11'd0, addr};
  endfunction

  // Register file model: read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (rf_en && rf_r_wn) rf_rdata <= rd_val(rf_addr);
    else rf_rdata <= 32'h0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    a_req = 0; a_r_wn = 1; a_addr = 0; a_wdata = 0;
    b_req = 0; b_r_wn = 1; b_addr = 0; b_wdata = 0;
  endtask

  task automatic do_reset;
    reset = 1;
    tick;
    tick;
    reset = 0;
  endtask

  typedef struct {
    logic       r_wn;
    logic [4:0] addr;
    logic       legal;
  } vec_t;

  vec_t vecs[6];

  initial begin
    rf_rdata = 0;
    idle_inputs();
    do_reset();

    // reset state
    check("rst_a_gnt", 32'(a_gnt), 0);
    check("rst_rf_en", 32'(rf_en), 0);
    check("rst_rf_r_wn", 32'(rf_r_wn), 1);
    check("rst_rf_addr", 32'(rf_addr), 0);
    check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    check("rst_rdata", a_rdata | b_rdata, 0);

    // A reads address 0
    a_req = 1; a_r_wn = 1; a_addr = 0;
    tick;
    check("rd0_a_gnt", 32'(a_gnt), 1);
    check("rd0_b_gnt", 32'(b_gnt), 0);
    check("rd0_rf_en", 32'(rf_en), 1);
    check("rd0_rf_r_wn", 32'(rf_r_wn), 1);
    check("rd0_rf_addr", 32'(rf_addr), 0);
    a_req = 0;
    tick;
    check("rd0_a_rvalid", 32'(a_rvalid), 1);
    check("rd0_a_rdata", a_rdata, 32'h4844_5256);
    check("rd0_a_err", 32'(a_err), 0);
    check("rd0_a_gnt_off", 32'(a_gnt), 0);
    tick;
    check("rd0_a_rvalid_off", 32'(a_rvalid), 0);
    check("rd0_a_rdata_off", a_rdata, 0);
    $display("[TB] txn A read 0 done");

    // B writes read-only address 1
    b_req = 1; b_r_wn = 0; b_addr = 1; b_wdata = 32'h1234;
    tick;
    check("wr1_b_gnt", 32'(b_gnt), 1);
    check("wr1_rf_en", 32'(rf_en), 0);
    b_req = 0;
    tick;
    check("wr1_b_rvalid", 32'(b_rvalid), 1);
    check("wr1_b_err", 32'(b_err), 1);
    check("wr1_b_rdata", b_rdata, 0);
    check("wr1_a_rvalid", 32'(a_rvalid), 0);
    tick;
    $display("[TB] txn B write 1 done");

    // legality boundaries, A alone
    vecs[0] = '{1'b0, 5'd1, 1'b0};
    vecs[1] = '{1'b0, 5'd2, 1'b1};
    vecs[2] = '{1'b1, 5'd5, 1'b1};
    vecs[3] = '{1'b1, 5'd6, 1'b0};
    vecs[4] = '{1'b0, 5'd6, 1'b0};
    vecs[5] = '{1'b1, 5'd9, 1'b0};
    for (int i = 0; i < 6; i++) begin
      a_req = 1; a_r_wn = vecs[i].r_wn; a_addr = vecs[i].addr; a_wdata = 32'hA5A5_0000 + i;
      tick;
      check($sformatf("vec%0d_a_gnt", i), 32'(a_gnt), 1);
      check($sformatf("vec%0d_rf_en", i), 32'(rf_en), 32'(vecs[i].legal));
      check($sformatf("vec%0d_rf_addr", i), 32'(rf_addr), 32'(vecs[i].addr));
      a_req = 0;
      tick;
      check($sformatf("vec%0d_a_rvalid", i), 32'(a_rvalid), 1);
      check($sformatf("vec%0d_a_err", i), 32'(a_err), 32'(!vecs[i].legal));
      check($sformatf("vec%0d_a_rdata", i), a_rdata,
            (vecs[i].legal && vecs[i].r_wn) ? rd_val(vecs[i].addr) : 32'h0);
      tick;
      $display("[TB] txn A vec %0d r_wn=%0d addr=%0d done", i, vecs[i].r_wn, vecs[i].addr);
    end

    // continuous contention: grants alternate A, B, A, B
    do_reset();
    a_req = 1; a_r_wn = 0; a_addr = 5; a_wdata = 32'hDEAD_BEEF;
    b_req = 1; b_r_wn = 1; b_addr = 3; b_wdata = 32'h5555_5555;
    for (int t = 0; t < 4; t++) begin
      logic exp_a;
      exp_a = (t % 2 == 0);
      tick;
      check($sformatf("rr%0d_a_gnt", t), 32'(a_gnt), 32'(exp_a));
      check($sformatf("rr%0d_b_gnt", t), 32'(b_gnt), 32'(!exp_a));
      check($sformatf("rr%0d_rf_en", t), 32'(rf_en), 1);
      if (exp_a) check($sformatf("rr%0d_rf_wdata", t), rf_wdata, 32'hDEAD_BEEF);
      else check($sformatf("rr%0d_rf_addr", t), 32'(rf_addr), 3);
      tick;
      check($sformatf("rr%0d_rvalid", t), {30'd0, a_rvalid, b_rvalid}, exp_a ? 32'd2 : 32'd1);
      check($sformatf("rr%0d_rdata", t), a_rdata | b_rdata, exp_a ? 32'h0 : 32'hC0DE_0003);
      tick;
      check($sformatf("rr%0d_idle", t), {28'd0, a_gnt, b_gnt, a_rvalid, b_rvalid}, 0);
      $display("[TB] txn contention %0d winner %s done", t, exp_a ? "A" : "B");
    end
    idle_inputs();
    tick;

    // B alone after reset, then simultaneous request goes to A
    do_reset();
    b_req = 1; b_r_wn = 1; b_addr = 4;
    tick;
    check("bonly_b_gnt", 32'(b_gnt), 1);
    check("bonly_a_gnt", 32'(a_gnt), 0);
    a_req = 1; a_r_wn = 1; a_addr = 2;
    tick;
    check("bonly_b_rdata", b_rdata, 32'hC0DE_0004);
    tick;
    tick;
    check("both_a_gnt", 32'(a_gnt), 1);
    check("both_b_gnt", 32'(b_gnt), 0);
    idle_inputs();
    tick;
    tick;
    $display("[TB] txn B-only then A/B done");

    // reset during ACCESS aborts; pointer back to B so A wins next
    do_reset();
    a_req = 1; a_r_wn = 1; a_addr = 0;
    tick;
    check("abort_a_gnt", 32'(a_gnt), 1);
    reset = 1;
    tick;
    check("abort_gnt", {30'd0, a_gnt, b_gnt}, 0);
    check("abort_rvalid", {30'd0, a_rvalid, b_rvalid}, 0);
    check("abort_rf_en", 32'(rf_en), 0);
    check("abort_rf_r_wn", 32'(rf_r_wn), 1);
    check("abort_rf_addr", 32'(rf_addr), 0);
    check("abort_rdata", a_rdata, 0);
    reset = 0;
    b_req = 1; b_r_wn = 1; b_addr = 3;
    tick;
    check("rereq_a_gnt", 32'(a_gnt), 1);
    check("rereq_b_gnt", 32'(b_gnt), 0);
    a_req = 0;
    tick;
    check("rereq_a_rvalid", 32'(a_rvalid), 1);
    check("rereq_a_rdata", a_rdata, 32'h4844_5256);
    tick;
    tick;
    check("rereq_b_gnt2", 32'(b_gnt), 1);
    idle_inputs();
    tick;
    tick;
    $display("[TB] txn reset abort done");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
